// File: rtl/pe_ctx_seq.sv
// pe_ctx_seq: context memory plus instruction sequencer for one PE.
// Contexts are loaded through a valid/ready port while idle. A start
// replays entries 0..len-1 once per iteration, one per cycle, then the
// PE is returned to NOP and a one-cycle done pulse is produced.
module pe_ctx_seq #(
  parameter int                INST_W   = 35,
  parameter int                AW       = 4,
  parameter int                DEPTH    = 16,
  parameter int                ITER_W   = 16,
  parameter logic [INST_W-1:0] NOP_INST = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [INST_W-1:0] cfg_data,
  input  logic              start,
  input  logic [AW:0]       ctx_len,
  input  logic [ITER_W-1:0] iter_cnt,
  input  logic              stall,
  output logic [INST_W-1:0] inst,
  output logic              inst_valid,
  output logic [AW-1:0]     pc,
  output logic              busy,
  output logic              done
);

  localparam logic [AW:0]       LEN_MAX  = (AW+1)'(DEPTH);
  localparam logic [AW:0]       LEN_ONE  = (AW+1)'(1);
  localparam logic [AW:0]       LEN_ZERO = '0;
  localparam logic [AW-1:0]     PC_ONE   = AW'(1);
  localparam logic [ITER_W-1:0] ITER_ONE = ITER_W'(1);
  localparam logic [ITER_W-1:0] ITER_ZERO = '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  // Context storage; deliberately has no reset so contents survive rst.
  logic [INST_W-1:0]   r_mem [DEPTH];

  logic [AW:0]         r_len;
  logic [AW:0]         w_len_nxt;
  logic [ITER_W-1:0]   r_iter;
  logic [ITER_W-1:0]   w_iter_nxt;
  logic [AW-1:0]       r_pc;
  logic [AW-1:0]       w_pc_nxt;
  logic [INST_W-1:0]   r_inst;
  logic [INST_W-1:0]   w_inst_nxt;
  logic                r_inst_vld;
  logic                w_inst_vld_nxt;
  logic                r_done;
  logic                w_done_nxt;

  logic                w_cfg_we;
  logic [AW:0]         w_len_clamped;
  logic                w_last_ctx;
  logic                w_last_iter;

  // Writes are only taken while idle, so a run never sees its program change.
  assign w_cfg_we      = cfg_valid && (r_state == S_IDLE);

  // A length above the memory depth simply plays the whole memory.
  assign w_len_clamped = (ctx_len > LEN_MAX) ? LEN_MAX : ctx_len;

  // r_len is at least 1 whenever these are consulted (RUN only).
  assign w_last_ctx    = ({1'b0, r_pc} == (r_len - LEN_ONE));
  assign w_last_iter   = (r_iter == ITER_ONE);

  // Config port: write the addressed context entry when accepted.
  always_ff @(posedge clk) begin
    if (w_cfg_we) begin
      r_mem[cfg_addr] <= cfg_data;
    end
  end

  // Sequencer next state and next issue word.
  always_comb begin
    w_state_nxt    = r_state;
    w_len_nxt      = r_len;
    w_iter_nxt     = r_iter;
    w_pc_nxt       = r_pc;
    w_inst_nxt     = NOP_INST;
    w_inst_vld_nxt = 1'b0;
    w_done_nxt     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_len_nxt  = w_len_clamped;
          w_iter_nxt = iter_cnt;
          w_pc_nxt   = '0;
          // An empty program finishes immediately without leaving IDLE.
          if ((w_len_clamped == LEN_ZERO) || (iter_cnt == ITER_ZERO)) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt = S_RUN;
          end
        end
      end

      S_RUN: begin
        // A stalled cycle issues a bubble and keeps pc/iter untouched so
        // the same context is issued once the stall lifts.
        if (!stall) begin
          w_inst_nxt     = r_mem[r_pc];
          w_inst_vld_nxt = 1'b1;
          if (w_last_ctx) begin
            w_pc_nxt   = '0;
            w_iter_nxt = r_iter - ITER_ONE;
            if (w_last_iter) begin
              w_state_nxt = S_FIN;
            end
          end else begin
            w_pc_nxt = r_pc + PC_ONE;
          end
        end
      end

      S_FIN: begin
        // Drain cycle: bubble on inst and raise done, stall has no effect.
        w_done_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Control and output registers; active-low synchronous reset aborts a run.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_pc       <= '0;
      r_inst     <= NOP_INST;
      r_inst_vld <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_inst     <= w_inst_nxt;
      r_inst_vld <= w_inst_vld_nxt;
      r_done     <= w_done_nxt;
    end
  end

  // Run parameters are reloaded on every accepted start, so they need no reset.
  always_ff @(posedge clk) begin
    r_len  <= w_len_nxt;
    r_iter <= w_iter_nxt;
  end

  assign cfg_ready  = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign inst       = r_inst;
  assign inst_valid = r_inst_vld;
  assign pc         = r_pc;
  assign done       = r_done;

endmodule

// File: tb/tb_pe_ctx_seq.sv
// Bench for pe_ctx_seq: directed steps, issued contexts checked by a queue.
module tb_pe_ctx_seq;

  localparam int INST_W = 35;
  localparam int AW     = 4;
  localparam int DEPTH  = 16;
  localparam int ITER_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [AW-1:0]     cfg_addr;
  logic [INST_W-1:0] cfg_data;
  logic              start;
  logic [AW:0]       ctx_len;
  logic [ITER_W-1:0] iter_cnt;
  logic              stall;
  logic [INST_W-1:0] inst;
  logic              inst_valid;
  logic [AW-1:0]     pc;
  logic              busy;
  logic              done;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [INST_W-1:0] exp_q [$];

  always #5 clk = ~clk;

  pe_ctx_seq #(
    .INST_W  (INST_W),
    .AW      (AW),
    .DEPTH   (DEPTH),
    .ITER_W  (ITER_W),
    .NOP_INST('0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .start     (start),
    .ctx_len   (ctx_len),
    .iter_cnt  (iter_cnt),
    .stall     (stall),
    .inst      (inst),
    .inst_valid(inst_valid),
    .pc        (pc),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic v, input logic b, input logic d);
    check({tag, "_vld"},  64'(inst_valid), 64'(v));
    check({tag, "_busy"}, 64'(busy),       64'(b));
    check({tag, "_done"}, 64'(done),       64'(d));
  endtask

  task automatic cfg_write(input int a, input logic [INST_W-1:0] d);
    cfg_valid = 1'b1;
    cfg_addr  = AW'(a);
    cfg_data  = d;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic start_run(input int len, input int iter);
    ctx_len  = (AW+1)'(len);
    iter_cnt = ITER_W'(iter);
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  // Monitor: every valid issue must match the head of the expectation queue;
  // every bubble must carry the NOP word.
  always @(negedge clk) begin
    logic [INST_W-1:0] e;
    if (inst_valid === 1'b1) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      check("issue", 64'(inst), 64'(e));
    end else begin
      check("bubble_nop", 64'(inst), 64'(0));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b0;
    cfg_valid = 1'b0;
    cfg_addr  = '0;
    cfg_data  = '0;
    start     = 1'b0;
    ctx_len   = '0;
    iter_cnt  = '0;
    stall     = 1'b0;
    repeat (2) tick();

    // Reset state
    check("rst_inst", 64'(inst), 64'(0));
    check("rst_pc", 64'(pc), 64'(0));
    check("rst_ready", 64'(cfg_ready), 64'(1));
    check_outs("rst", 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) cfg_write(i, INST_W'(i + 1));

    // 4 contexts x 2 iterations
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++) exp_q.push_back(INST_W'(i + 1));
    start_run(4, 2);
    check_outs("t1_accept", 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      tick();
      check_outs("t1_issue", 1'b1, 1'b1, 1'b0);
    end
    tick();
    check_outs("t1_end", 1'b0, 1'b0, 1'b1);
    check("t1_end_inst", 64'(inst), 64'(0));
    tick();
    check_outs("t1_after", 1'b0, 1'b0, 1'b0);

    // Stall for two cycles after the second issue
    for (int i = 0; i < 3; i++) exp_q.push_back(INST_W'(i + 1));
    start_run(3, 1);
    tick();
    check_outs("t2_i1", 1'b1, 1'b1, 1'b0);
    tick();
    check_outs("t2_i2", 1'b1, 1'b1, 1'b0);
    stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      check_outs("t2_stall", 1'b0, 1'b1, 1'b0);
      check("t2_stall_pc", 64'(pc), 64'(2));
    end
    stall = 1'b0;
    tick();
    check_outs("t2_i3", 1'b1, 1'b1, 1'b0);
    tick();
    check_outs("t2_end", 1'b0, 1'b0, 1'b1);
    tick();

    // Degenerate runs: zero length, then zero iterations
    start_run(0, 5);
    check_outs("t3_len0", 1'b0, 1'b0, 1'b1);
    tick();
    check_outs("t3_len0_after", 1'b0, 1'b0, 1'b0);
    start_run(2, 0);
    check_outs("t3_iter0", 1'b0, 1'b0, 1'b1);
    tick();
    check_outs("t3_iter0_after", 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a 4x3 run
    for (int i = 0; i < 5; i++) exp_q.push_back(INST_W'((i % 4) + 1));
    start_run(4, 3);
    for (int k = 0; k < 5; k++) begin
      tick();
      check_outs("t5_issue", 1'b1, 1'b1, 1'b0);
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check_outs("t5_rst", 1'b0, 1'b0, 1'b0);
    check("t5_rst_inst", 64'(inst), 64'(0));
    check("t5_rst_pc", 64'(pc), 64'(0));
    tick();
    check_outs("t5_no_done", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) exp_q.push_back(INST_W'(i + 1));
    start_run(4, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_outs("t5_replay", 1'b1, 1'b1, 1'b0);
    end
    tick();
    check_outs("t5_replay_end", 1'b0, 1'b0, 1'b1);
    tick();

    // Config write attempted during a run is refused
    exp_q.push_back(INST_W'(1));
    exp_q.push_back(INST_W'(2));
    start_run(2, 1);
    cfg_valid = 1'b1;
    cfg_addr  = '0;
    cfg_data  = INST_W'(35'h7FF);
    check("t4_ready_run", 64'(cfg_ready), 64'(0));
    tick();
    check("t4_ready_i1", 64'(cfg_ready), 64'(0));
    tick();
    check("t4_ready_fin", 64'(cfg_ready), 64'(0));
    tick();
    cfg_valid = 1'b0;
    check_outs("t4_end", 1'b0, 1'b0, 1'b1);
    exp_q.push_back(INST_W'(1));
    start_run(1, 1);
    tick();
    check_outs("t4_rerun", 1'b1, 1'b1, 1'b0);
    tick();
    check_outs("t4_rerun_end", 1'b0, 1'b0, 1'b1);

    // Write and start on the same edge: first issue sees the new word
    exp_q.push_back(INST_W'(35'h7FF));
    cfg_valid = 1'b1;
    cfg_addr  = '0;
    cfg_data  = INST_W'(35'h7FF);
    start_run(1, 1);
    cfg_valid = 1'b0;
    tick();
    check_outs("t4_same_edge", 1'b1, 1'b1, 1'b0);
    tick();
    check_outs("t4_same_edge_end", 1'b0, 1'b0, 1'b1);

    // Full memory with length clamped from 31 to 16
    for (int i = 0; i < DEPTH; i++) cfg_write(i, INST_W'(i + 16));
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(INST_W'(i + 16));
    start_run(31, 1);
    for (int k = 0; k < DEPTH; k++) begin
      tick();
      check_outs("t6_issue", 1'b1, 1'b1, 1'b0);
      check("t6_pc", 64'(pc), 64'((k + 1) % DEPTH));
    end
    tick();
    check_outs("t6_end", 1'b0, 1'b0, 1'b1);
    tick();

    // Maximum iteration count keeps running; abort with reset
    for (int k = 0; k < 4; k++) exp_q.push_back(INST_W'(16));
    start_run(1, 16'hFFFF);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_outs("t7_issue", 1'b1, 1'b1, 1'b0);
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check_outs("t7_rst", 1'b0, 1'b0, 1'b0);
    tick();

    check("q_drained", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
